// File: rtl/mfp_ahb_lite_eic_prio.sv
// AHB-Lite EIC-mode interrupt controller: sense, mask, pending and priority arbitration.
// Optional EIC_PRIORITY_EN adds per-channel EIPR0..3 priority registers.
module mfp_ahb_lite_eic_prio #(
  parameter int CHANNELS    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [31:0]         HADDR,
  input  logic                HSEL,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HSIZE,
  input  logic [31:0]         HWDATA,
  output logic [31:0]         HRDATA,
  output logic                HREADY,
  output logic                HRESP,
  input  logic [CHANNELS-1:0] signal,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic [16:0]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic                EIC_Present,
  input  logic                EIC_IAck,
  input  logic [7:0]          EIC_IPL,
  input  logic [5:0]          EIC_IVN,
  input  logic [16:0]         EIC_ION
);

  localparam logic [32:0] CH_M33  = (33'd1 << CHANNELS) - 33'd1;
  localparam logic [31:0] CH_MASK = CH_M33[31:0];
  localparam logic [64:0] SN_M65  = (65'd1 << (2 * CHANNELS)) - 65'd1;
  localparam logic [63:0] SN_MASK = SN_M65[63:0];

  logic [3:0]  a_idx;
  logic        a_wr;
  logic        we;
  logic        eicr_q;
  logic [31:0] msk_q;
  logic [31:0] pend_q;
  logic [31:0] pend_d;
  logic [63:0] sns_q;
  logic [31:0] sig_in;
  logic [31:0] sync_q [SYNC_STAGES];
  logic [31:0] hist_q;
  logic [31:0] sig_s;
  logic [31:0] rise;
  logic [31:0] fall;
  logic [31:0] w1c;
  logic [31:0] w1s;
  logic [31:0] ackv;
  logic [7:0]  prio [32];
  logic [7:0]  win_p;
  logic [5:0]  win_i;
  logic [7:0]  eic_int_q;
  logic [5:0]  eic_vec_q;
  logic        ack_vld;
  logic        ack_d;
  logic        unused_ok;

`ifdef EIC_PRIORITY_EN
  localparam logic [128:0] PR_M129 = (129'd1 << (4 * CHANNELS)) - 129'd1;
  localparam logic [127:0] PR_MASK = PR_M129[127:0];
  logic [127:0] eipr_q;
`endif

  assign HREADY        = 1'b1;
  assign HRESP         = 1'b0;
  assign EIC_Offset    = '0;
  assign EIC_ShadowSet = '0;
  assign EIC_Present   = 1'b1;
  assign EIC_Interrupt = eic_int_q;
  assign EIC_Vector    = eic_vec_q;
  assign sig_in        = 32'(signal);
  assign we            = a_wr;
  assign ack_vld       = EIC_IAck && (eic_int_q != 8'd0);
  assign unused_ok     = ^{HADDR[31:6], HADDR[1:0], EIC_IPL, EIC_IVN, EIC_ION};

  // a_wr already folds in the word-size check; index is kept across idles
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_idx <= '0;
      a_wr  <= 1'b0;
    end else if (HSEL && HTRANS[1]) begin
      a_idx <= HADDR[5:2];
      a_wr  <= HWRITE && (HSIZE == 3'b010);
    end else begin
      a_wr  <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      eicr_q <= 1'b0;
      msk_q  <= '0;
      sns_q  <= '0;
`ifdef EIC_PRIORITY_EN
      eipr_q <= '0;
`endif
    end else if (we) begin
      case (a_idx)
        4'd0: eicr_q <= HWDATA[0];
        4'd1: msk_q <= HWDATA & CH_MASK;
        4'd4: sns_q[31:0] <= HWDATA & SN_MASK[31:0];
        4'd5: sns_q[63:32] <= HWDATA & SN_MASK[63:32];
`ifdef EIC_PRIORITY_EN
        4'd8:  eipr_q[31:0]   <= HWDATA & PR_MASK[31:0];
        4'd9:  eipr_q[63:32]  <= HWDATA & PR_MASK[63:32];
        4'd10: eipr_q[95:64]  <= HWDATA & PR_MASK[95:64];
        4'd11: eipr_q[127:96] <= HWDATA & PR_MASK[127:96];
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    HRDATA = '0;
    case (a_idx)
      4'd0: HRDATA = {31'b0, eicr_q};
      4'd1: HRDATA = msk_q;
      4'd2: HRDATA = pend_q;
      4'd4: HRDATA = sns_q[31:0];
      4'd5: HRDATA = sns_q[63:32];
`ifdef EIC_PRIORITY_EN
      4'd8:  HRDATA = eipr_q[31:0];
      4'd9:  HRDATA = eipr_q[63:32];
      4'd10: HRDATA = eipr_q[95:64];
      4'd11: HRDATA = eipr_q[127:96];
`endif
      default: HRDATA = '0;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      hist_q <= '0;
      pend_q <= '0;
    end else begin
      sync_q[0] <= sig_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      hist_q <= sync_q[SYNC_STAGES-1];
      pend_q <= pend_d;
    end
  end

  // Edge modes: a set source beats any clear in the same cycle
  always_comb begin
    sig_s  = sync_q[SYNC_STAGES-1];
    rise   = sig_s & ~hist_q;
    fall   = ~sig_s & hist_q;
    w1c    = (we && a_idx == 4'd2) ? HWDATA : '0;
    w1s    = (we && a_idx == 4'd3) ? HWDATA : '0;
    ackv   = ack_vld ? (32'd1 << eic_vec_q) : '0;
    pend_d = pend_q;
    for (int i = 0; i < 32; i++) begin
      unique case (sns_q[2*i +: 2])
        2'b00: pend_d[i] = 1'b0;
        2'b01: pend_d[i] = sig_s[i];
        2'b10,
        2'b11: begin
          if ((sns_q[2*i] ? (rise[i] | fall[i]) : rise[i]) | w1s[i])
            pend_d[i] = 1'b1;
          else if (w1c[i] | ackv[i])
            pend_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
`ifdef EIC_PRIORITY_EN
      prio[i] = {4'b0, eipr_q[4*i +: 4]};
`else
      prio[i] = 8'(i + 1);
`endif
    end
  end

  // Strict compare keeps the lowest index on ties and skips prio 0
  always_comb begin
    win_p = '0;
    win_i = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (pend_q[i] && msk_q[i] && eicr_q && (prio[i] > win_p)) begin
        win_p = prio[i];
        win_i = 6'(i);
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      eic_int_q <= '0;
      eic_vec_q <= '0;
      ack_d     <= 1'b0;
    end else begin
      ack_d <= ack_vld;
      if (ack_vld || ack_d) begin
        eic_int_q <= '0;
        eic_vec_q <= '0;
      end else begin
        eic_int_q <= win_p;
        eic_vec_q <= win_i;
      end
    end
  end

endmodule

// File: tb/tb_mfp_ahb_lite_eic_prio.sv
// Directed bench for mfp_ahb_lite_eic_prio with a read-data scoreboard.
// Priority-mode build programs EIPR0 so channel i has priority i+1.
module tb_mfp_ahb_lite_eic_prio;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic        HSEL;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] signal;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic [16:0] EIC_Offset;
  logic [3:0]  EIC_ShadowSet;
  logic        EIC_Present;
  logic        EIC_IAck;
  logic [7:0]  EIC_IPL;
  logic [5:0]  EIC_IVN;
  logic [16:0] EIC_ION;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  mfp_ahb_lite_eic_prio #(.CHANNELS(32), .SYNC_STAGES(2)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HSEL(HSEL),
    .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .signal(signal),
    .EIC_Interrupt(EIC_Interrupt), .EIC_Vector(EIC_Vector),
    .EIC_Offset(EIC_Offset), .EIC_ShadowSet(EIC_ShadowSet),
    .EIC_Present(EIC_Present), .EIC_IAck(EIC_IAck), .EIC_IPL(EIC_IPL),
    .EIC_IVN(EIC_IVN), .EIC_ION(EIC_ION)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic ahb_write(input int idx, input logic [31:0] d,
                           input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = sz;
    HADDR = 32'(idx) << 2;
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_read(input int idx, input logic [31:0] exp,
                          input string tag);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'b010;
    HADDR = 32'(idx) << 2;
    exp_q.push_back(exp);
    tick(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, HRDATA);
    end else begin
      chk(tag, HRDATA, exp_q.pop_front());
    end
  endtask

  task automatic chk_eic(input string tag, input logic [7:0] ei,
                         input logic [5:0] ev);
    chk({tag, "_int"}, 32'(EIC_Interrupt), 32'(ei));
    chk({tag, "_vec"}, 32'(EIC_Vector), 32'(ev));
  endtask

  task automatic iack();
    EIC_IAck = 1'b1;
    tick(1);
    EIC_IAck = 1'b0;
  endtask

  initial begin
    HRESETn = 1'b0; HADDR = '0; HSEL = 1'b0; HWRITE = 1'b0;
    HTRANS = 2'b00; HSIZE = 3'b010; HWDATA = '0; signal = '0;
    EIC_IAck = 1'b0; EIC_IPL = '0; EIC_IVN = '0; EIC_ION = '0;
    tick(2);
    chk_eic("rst", 8'd0, 6'd0);
    chk("rst_hready", 32'(HREADY), 32'd1);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_present", 32'(EIC_Present), 32'd1);
    HRESETn = 1'b1;
    tick(1);
    for (int r = 0; r < 12; r++) ahb_read(r, 32'd0, $sformatf("rst_reg%0d", r));

    // channel 0 rising edge
`ifdef EIC_PRIORITY_EN
    ahb_write(8, 32'h8765_4321, 3'b010);
`endif
    ahb_write(0, 32'h1, 3'b010);
    ahb_write(1, 32'h1, 3'b010);
    ahb_write(4, 32'h2, 3'b010);
    tick(1);
    signal[0] = 1'b1;
    tick(2);
    chk_eic("ch0_early", 8'd0, 6'd0);
    ahb_read(2, 32'h1, "ch0_eifr");
    chk_eic("ch0_arb_lat", 8'd0, 6'd0);
    tick(1);
    chk_eic("ch0_req", 8'd1, 6'd0);
    iack();
    chk_eic("ch0_ack", 8'd0, 6'd0);
    ahb_read(2, 32'h0, "ch0_eifr_clr");
    tick(3);
    chk_eic("ch0_idle", 8'd0, 6'd0);
    signal[0] = 1'b0;

    // ch1 rising + ch2 level
    ahb_write(1, 32'h6, 3'b010);
    ahb_write(4, 32'h18, 3'b010);
    tick(1);
    signal[1] = 1'b1;
    signal[2] = 1'b1;
    tick(5);
    chk_eic("lv_win", 8'd3, 6'd2);
    iack();
    chk_eic("lv_ack", 8'd0, 6'd0);
    tick(3);
    chk_eic("lv_rearb", 8'd3, 6'd2);
    ahb_read(2, 32'h6, "lv_eifr");
    ahb_write(2, 32'h4, 3'b010);
    tick(1);
    ahb_read(2, 32'h6, "lv_w1c_ignored");
    signal[2] = 1'b0;
    tick(5);
    chk_eic("lv_drop", 8'd2, 6'd1);
    ahb_read(2, 32'h2, "lv_eifr_drop");
    iack();
    tick(3);
    chk_eic("lv_none", 8'd0, 6'd0);
    ahb_read(2, 32'h0, "lv_eifr_none");
    signal[1] = 1'b0;

    // ch3 any-edge: edge set coincides with W1C
    ahb_write(4, 32'hD8, 3'b010);
    tick(1);
    signal[3] = 1'b1;
    tick(1);
    ahb_write(2, 32'h8, 3'b010);
    tick(1);
    ahb_read(2, 32'h8, "set_wins");
    chk_eic("masked", 8'd0, 6'd0);
    ahb_write(2, 32'h8, 3'b010);
    tick(1);
    ahb_read(2, 32'h0, "w1c");
    ahb_write(3, 32'h8, 3'b010);
    ahb_read(3, 32'h0, "eifrs_rd0");
    ahb_read(2, 32'h8, "eifrs_set");
    ahb_write(2, 32'h8, 3'b010);
    tick(1);
    signal[3] = 1'b0;
    tick(4);
    ahb_read(2, 32'h8, "fall_edge");

    // back-to-back and byte write
    ahb_write(1, 32'h90, 3'b010);
    ahb_read(1, 32'h90, "b2b");
    ahb_write(1, 32'hFFFF, 3'b000);
    tick(1);
    ahb_read(1, 32'h90, "byte_wr");

    // ch4 and ch7 via EIFRS
    ahb_write(4, 32'h8200, 3'b010);
    ahb_write(3, 32'h90, 3'b010);
    tick(4);
    chk_eic("hi_win", 8'd8, 6'd7);
    iack();
    chk_eic("hi_ack", 8'd0, 6'd0);
    tick(3);
    chk_eic("hi_next", 8'd5, 6'd4);
    ahb_read(2, 32'h10, "hi_eifr");

    // global enable
    ahb_write(0, 32'h0, 3'b010);
    tick(2);
    chk_eic("gen_off", 8'd0, 6'd0);
    ahb_read(2, 32'h10, "gen_pend");
    ahb_write(0, 32'h1, 3'b010);
    tick(2);
    chk_eic("gen_on", 8'd5, 6'd4);

    ahb_write(12, 32'hFFFF_FFFF, 3'b010);
    ahb_read(12, 32'h0, "unmapped");
    ahb_read(5, 32'h0, "sense_h");
    ahb_write(8, 32'h1234_5678, 3'b010);
`ifdef EIC_PRIORITY_EN
    ahb_read(8, 32'h1234_5678, "eipr0");
`else
    ahb_read(8, 32'h0, "eipr0");
`endif

    // reset during a write data phase
    ahb_write(1, 32'hFF, 3'b010);
    #2;
    HRESETn = 1'b0;
    tick(1);
    HRESETn = 1'b1;
    tick(1);
    ahb_read(1, 32'h0, "rst_abort");
    ahb_read(2, 32'h0, "rst_pend");
    ahb_read(0, 32'h0, "rst_eicr");
    chk_eic("rst2", 8'd0, 6'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
